// File: rtl/cfu_initiator_if.sv
// CFU request/response channel between an initiator (master) and a custom function unit (slave).
interface cfu_interface #(
   parameter int ID_W = 4
);
   logic            req_valid;
   logic            req_ready;
   logic [ID_W-1:0] req_id;
   logic [9:0]      req_function_id;
   logic [31:0]     req_data0;
   logic [31:0]     req_data1;
   logic            resp_valid;
   logic            resp_ready;
   logic [ID_W-1:0] resp_id;
   logic [1:0]      resp_status;
   logic [31:0]     resp_data;

   modport master (
      output req_valid, req_id, req_function_id, req_data0, req_data1, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_status, resp_data
   );

   modport slave (
      input  req_valid, req_id, req_function_id, req_data0, req_data1, resp_ready,
      output req_ready, resp_valid, resp_id, resp_status, resp_data
   );
endinterface

// File: rtl/cfu_initiator.sv
// Core-side initiator for a custom function unit: registers issued ops, bounds in-flight requests,
// and buffers one response for writeback. Optional response-ID checking via `CFU_ID_CHECK_EN.
module cfu_initiator #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int ID_W            = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [ID_W-1:0]   issue_id,
   input  logic [9:0]        issue_fn,
   input  logic [31:0]       issue_rs1,
   input  logic [31:0]       issue_rs2,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [ID_W-1:0]   wb_id,
   output logic [31:0]       wb_data,
   output logic              wb_error,
   output logic              id_mismatch,
   cfu_interface.master      cfu
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic              req_valid_q;
   logic [ID_W-1:0]   req_id_q;
   logic [9:0]        req_fn_q;
   logic [31:0]       req_d0_q;
   logic [31:0]       req_d1_q;
   logic [CNT_W-1:0]  outstanding;
   logic              wb_valid_q;
   logic [ID_W-1:0]   wb_id_q;
   logic [31:0]       wb_data_q;
   logic              wb_error_q;
   logic              resp_id_bad;

   logic issue_hs, req_hs, resp_hs, wb_hs;

   // A held request that drains this cycle frees its slot, so req_ready may reopen issue.
   assign issue_ready = (!req_valid_q || cfu.req_ready) &&
                        ((int'(outstanding) + int'(req_valid_q)) < MAX_OUTSTANDING);
   assign cfu.resp_ready = !wb_valid_q || wb_ready;

   assign issue_hs = issue_valid && issue_ready;
   assign req_hs   = req_valid_q && cfu.req_ready;
   assign resp_hs  = cfu.resp_valid && cfu.resp_ready;
   assign wb_hs    = wb_valid_q && wb_ready;

   assign cfu.req_valid       = req_valid_q;
   assign cfu.req_id          = req_id_q;
   assign cfu.req_function_id = req_fn_q;
   assign cfu.req_data0       = req_d0_q;
   assign cfu.req_data1       = req_d1_q;

   assign wb_valid = wb_valid_q;
   assign wb_id    = wb_id_q;
   assign wb_data  = wb_data_q;
   assign wb_error = wb_error_q;

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_valid_q <= 1'b0;
      end else if (issue_hs) begin
         req_valid_q <= 1'b1;
      end else if (req_hs) begin
         req_valid_q <= 1'b0;
      end
   end

   // NOTE: payload registers carry no reset; their valid flag qualifies them.
   always_ff @(posedge clk) begin
      if (issue_hs) begin
         req_id_q <= issue_id;
         req_fn_q <= issue_fn;
         req_d0_q <= issue_rs1;
         req_d1_q <= issue_rs2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding <= '0;
      end else if (req_hs && !resp_hs) begin
         outstanding <= outstanding + CNT_W'(1);
      end else if (resp_hs && !req_hs) begin
         outstanding <= outstanding - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_q <= 1'b0;
      end else if (resp_hs) begin
         wb_valid_q <= 1'b1;
      end else if (wb_hs) begin
         wb_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (resp_hs) begin
         wb_id_q    <= cfu.resp_id;
         wb_data_q  <= cfu.resp_data;
         wb_error_q <= (cfu.resp_status != 2'b00) || resp_id_bad;
      end
   end

`ifdef CFU_ID_CHECK_EN
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [ID_W-1:0]  id_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             mismatch_q;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PTR_W'(1);
   endfunction

   // FIFO occupancy equals the outstanding count, so an empty FIFO is outstanding == 0.
   assign resp_id_bad = (outstanding == '0) || (cfu.resp_id != id_fifo[rd_ptr]);
   assign id_mismatch = mismatch_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         mismatch_q <= 1'b0;
      end else begin
         if (req_hs)                wr_ptr     <= ptr_next(wr_ptr);
         if (resp_hs)               rd_ptr     <= ptr_next(rd_ptr);
         if (resp_hs && resp_id_bad) mismatch_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (req_hs) id_fifo[wr_ptr] <= req_id_q;
   end
`else
   assign resp_id_bad = 1'b0;
   assign id_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_cfu_initiator.sv
// Directed bench for cfu_initiator: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_cfu_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic        issue_ready;
   logic [3:0]  issue_id;
   logic [9:0]  issue_fn;
   logic [31:0] issue_rs1, issue_rs2;
   logic        wb_valid, wb_ready, wb_error, id_mismatch;
   logic [3:0]  wb_id;
   logic [31:0] wb_data;

   int errors = 0;
   int checks = 0;
   int req_hs_cnt = 0;
   int wb_hs_cnt = 0;
   int base;

`ifdef CFU_ID_CHECK_EN
   localparam logic ID_CHK = 1'b1;
`else
   localparam logic ID_CHK = 1'b0;
`endif

   cfu_interface #(.ID_W(4)) cfu_bus ();

   cfu_initiator #(.MAX_OUTSTANDING(4), .ID_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_id    (issue_id),
      .issue_fn    (issue_fn),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_id       (wb_id),
      .wb_data     (wb_data),
      .wb_error    (wb_error),
      .id_mismatch (id_mismatch),
      .cfu         (cfu_bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && cfu_bus.req_valid && cfu_bus.req_ready) req_hs_cnt++;
      if (!rst && wb_valid && wb_ready) wb_hs_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        iv;
      logic [3:0]  iid;
      logic [9:0]  ifn;
      logic [31:0] rs1, rs2;
      logic        rr, rv;
      logic [3:0]  rid;
      logic [1:0]  st;
      logic [31:0] rdata;
      logic        wr;
      logic        e_ir, e_rv;
      logic [3:0]  e_rqid;
      logic [31:0] e_d0;
      logic        e_rsr, e_wv;
      logic [3:0]  e_wid;
      logic [31:0] e_wd;
      logic        e_we;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mk(
      input logic iv, input logic [3:0] iid, input logic [9:0] ifn,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic rr, input logic rv,
      input logic [3:0] rid, input logic [1:0] st, input logic [31:0] rdata, input logic wr,
      input logic e_ir, input logic e_rv, input logic [3:0] e_rqid, input logic [31:0] e_d0,
      input logic e_rsr, input logic e_wv, input logic [3:0] e_wid, input logic [31:0] e_wd,
      input logic e_we);
      vec_t v;
      v.iv = iv; v.iid = iid; v.ifn = ifn; v.rs1 = rs1; v.rs2 = rs2; v.rr = rr; v.rv = rv;
      v.rid = rid; v.st = st; v.rdata = rdata; v.wr = wr;
      v.e_ir = e_ir; v.e_rv = e_rv; v.e_rqid = e_rqid; v.e_d0 = e_d0; v.e_rsr = e_rsr;
      v.e_wv = e_wv; v.e_wid = e_wid; v.e_wd = e_wd; v.e_we = e_we;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic drive(
      input logic iv, input logic [3:0] iid, input logic [9:0] ifn, input logic [31:0] rs1,
      input logic [31:0] rs2, input logic rr, input logic rv, input logic [3:0] rid,
      input logic [1:0] st, input logic [31:0] rdata, input logic wr);
      issue_valid = iv; issue_id = iid; issue_fn = ifn; issue_rs1 = rs1; issue_rs2 = rs2;
      cfu_bus.req_ready = rr; cfu_bus.resp_valid = rv; cfu_bus.resp_id = rid;
      cfu_bus.resp_status = st; cfu_bus.resp_data = rdata; wb_ready = wr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Single op, then an error status interleaved with back-to-back issue.
      vecs[0]  = mk(0,0,10'h000,0,0,0, 0,0,2'b00,0,1,                   1,0,0,0,1,0,0,0,0);
      vecs[1]  = mk(1,3,10'h001,32'h12345678,32'h9ABCDEF0,0, 0,0,0,0,1, 1,0,0,0,1,0,0,0,0);
      vecs[2]  = mk(0,0,0,0,0,1, 0,0,0,0,1,                             1,1,3,32'h12345678,1,0,0,0,0);
      vecs[3]  = mk(0,0,0,0,0,1, 1,3,2'b00,32'hCAFEF00D,1,              1,0,0,0,1,0,0,0,0);
      vecs[4]  = mk(0,0,0,0,0,1, 0,0,0,0,0,                             1,0,0,0,0,1,3,32'hCAFEF00D,0);
      vecs[5]  = mk(0,0,0,0,0,1, 0,0,0,0,1,                             1,0,0,0,1,1,3,32'hCAFEF00D,0);
      vecs[6]  = mk(0,0,0,0,0,1, 0,0,0,0,1,                             1,0,0,0,1,0,0,0,0);
      vecs[7]  = mk(1,5,10'h3FF,32'h1,32'h2,1, 0,0,0,0,1,               1,0,0,0,1,0,0,0,0);
      vecs[8]  = mk(1,6,10'h002,32'hAAAA,32'hBBBB,1, 0,0,0,0,1,         1,1,5,32'h1,1,0,0,0,0);
      vecs[9]  = mk(0,0,0,0,0,1, 1,5,2'b01,32'hDEAD0001,1,              1,1,6,32'hAAAA,1,0,0,0,0);
      vecs[10] = mk(0,0,0,0,0,1, 1,6,2'b10,32'h600D0006,0,              1,0,0,0,0,1,5,32'hDEAD0001,1);
      vecs[11] = mk(0,0,0,0,0,1, 1,6,2'b10,32'h600D0006,1,              1,0,0,0,1,1,5,32'hDEAD0001,1);
      vecs[12] = mk(0,0,0,0,0,1, 0,0,0,0,1,                             1,0,0,0,1,1,6,32'h600D0006,1);
      vecs[13] = mk(0,0,0,0,0,1, 0,0,0,0,1,                             1,0,0,0,1,0,0,0,0);

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].iv, vecs[i].iid, vecs[i].ifn, vecs[i].rs1, vecs[i].rs2, vecs[i].rr,
               vecs[i].rv, vecs[i].rid, vecs[i].st, vecs[i].rdata, vecs[i].wr);
         check($sformatf("vec%0d issue_ready", i), issue_ready, vecs[i].e_ir);
         check($sformatf("vec%0d req_valid", i), cfu_bus.req_valid, vecs[i].e_rv);
         if (vecs[i].e_rv) begin
            check($sformatf("vec%0d req_id", i), cfu_bus.req_id, vecs[i].e_rqid);
            check($sformatf("vec%0d req_data0", i), cfu_bus.req_data0, vecs[i].e_d0);
         end
         check($sformatf("vec%0d resp_ready", i), cfu_bus.resp_ready, vecs[i].e_rsr);
         check($sformatf("vec%0d wb_valid", i), wb_valid, vecs[i].e_wv);
         if (vecs[i].e_wv) begin
            check($sformatf("vec%0d wb_id", i), wb_id, vecs[i].e_wid);
            check($sformatf("vec%0d wb_data", i), wb_data, vecs[i].e_wd);
            check($sformatf("vec%0d wb_error", i), wb_error, vecs[i].e_we);
         end
         tick();
      end

      // Backpressure: request held stable for 5 stalled cycles, exactly one handshake.
      drive(1, 7, 10'h055, 32'h11112222, 32'h33334444, 0, 0, 0, 0, 0, 1);
      check("bp issue_ready first", issue_ready, 1'b1);
      tick();
      base = req_hs_cnt;
      for (int c = 0; c < 5; c++) begin
         drive(1, 8, 10'h0AA, 32'hFFFF0000, 32'h0000FFFF, 0, 0, 0, 0, 0, 1);
         check("bp req_valid", cfu_bus.req_valid, 1'b1);
         check("bp req_id", cfu_bus.req_id, 4'd7);
         check("bp req_fn", cfu_bus.req_function_id, 10'h055);
         check("bp req_data0", cfu_bus.req_data0, 32'h11112222);
         check("bp req_data1", cfu_bus.req_data1, 32'h33334444);
         check("bp issue_ready", issue_ready, 1'b0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      check("bp release issue_ready", issue_ready, 1'b1);
      tick();
      check("bp req_valid dropped", cfu_bus.req_valid, 1'b0);
      check("bp handshake count", req_hs_cnt - base, 1);
      drive(0, 0, 0, 0, 0, 1, 1, 7, 0, 32'h77777777, 1);
      tick();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      check("bp wb_id", wb_id, 4'd7);
      check("bp wb_data", wb_data, 32'h77777777);
      tick();

      // Outstanding limit, then writeback stall with responses queued at the CFU.
      base = req_hs_cnt;
      for (int k = 1; k <= 4; k++) begin
         drive(1, 4'(k), 10'h010, 32'(k), 0, 1, 0, 0, 0, 0, 1);
         check($sformatf("lim issue_ready id%0d", k), issue_ready, 1'b1);
         tick();
      end
      drive(1, 5, 10'h010, 0, 0, 1, 0, 0, 0, 0, 1);
      check("lim issue_ready at limit", issue_ready, 1'b0);
      tick();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      check("lim issue_ready full", issue_ready, 1'b0);
      check("lim req_valid", cfu_bus.req_valid, 1'b0);
      check("lim handshakes", req_hs_cnt - base, 4);
      tick();
      base = wb_hs_cnt;
      drive(0, 0, 0, 0, 0, 1, 1, 1, 0, 32'h1001, 1);
      check("lim resp_ready", cfu_bus.resp_ready, 1'b1);
      check("lim issue_ready still full", issue_ready, 1'b0);
      tick();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      check("lim issue_ready reopened", issue_ready, 1'b1);
      check("lim wb_id1", wb_id, 4'd1);
      tick();
      drive(0, 0, 0, 0, 0, 1, 1, 2, 0, 32'h1002, 0);
      check("stall resp_ready empty buf", cfu_bus.resp_ready, 1'b1);
      tick();
      for (int c = 0; c < 2; c++) begin
         drive(0, 0, 0, 0, 0, 1, 1, 3, 0, 32'h1003, 0);
         check("stall resp_ready blocked", cfu_bus.resp_ready, 1'b0);
         check("stall wb_id2 held", wb_id, 4'd2);
         check("stall wb_data2 held", wb_data, 32'h1002);
         tick();
      end
      drive(0, 0, 0, 0, 0, 1, 1, 3, 0, 32'h1003, 1);
      check("stall resp_ready drain", cfu_bus.resp_ready, 1'b1);
      check("stall wb_id2", wb_id, 4'd2);
      tick();
      drive(0, 0, 0, 0, 0, 1, 1, 4, 0, 32'h1004, 1);
      check("stall wb_id3", wb_id, 4'd3);
      check("stall wb_data3", wb_data, 32'h1003);
      tick();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      check("stall wb_id4", wb_id, 4'd4);
      check("stall wb_err4", wb_error, 1'b0);
      tick();
      check("stall wb_valid idle", wb_valid, 1'b0);
      check("stall wb count", wb_hs_cnt - base, 4);

      // Out-of-order responses: ids 1,2 issued, CFU answers 2 then 1.
      drive(1, 1, 10'h020, 0, 0, 1, 0, 0, 0, 0, 1);
      tick();
      drive(1, 2, 10'h020, 0, 0, 1, 0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0, 1, 1, 2, 0, 32'h2222, 1);
      tick();
      drive(0, 0, 0, 0, 0, 1, 1, 1, 0, 32'h1111, 1);
      check("ooo wb_id2", wb_id, 4'd2);
      check("ooo wb_err2", wb_error, ID_CHK);
      check("ooo id_mismatch", id_mismatch, ID_CHK);
      tick();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      check("ooo wb_id1", wb_id, 4'd1);
      check("ooo wb_data1", wb_data, 32'h1111);
      check("ooo wb_err1", wb_error, ID_CHK);
      tick();

      // Reset mid-operation: 3 outstanding, a held request and a buffered response.
      for (int k = 9; k <= 12; k++) begin
         drive(1, 4'(k), 10'h030, 0, 0, 1, 0, 0, 0, 0, 1);
         tick();
      end
      drive(0, 0, 0, 0, 0, 1, 1, 9, 0, 32'h9999, 0);
      tick();
      drive(1, 13, 10'h030, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst pre wb_valid", wb_valid, 1'b1);
      check("rst pre issue_ready", issue_ready, 1'b1);
      tick();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst pre req_valid", cfu_bus.req_valid, 1'b1);
      tick();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst wb_valid", wb_valid, 1'b0);
      check("rst req_valid", cfu_bus.req_valid, 1'b0);
      check("rst issue_ready", issue_ready, 1'b1);
      check("rst resp_ready", cfu_bus.resp_ready, 1'b1);
      check("rst id_mismatch", id_mismatch, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         drive(1, 4'(k), 10'h040, 0, 0, 1, 0, 0, 0, 0, 1);
         check($sformatf("rst post issue_ready %0d", k), issue_ready, 1'b1);
         tick();
      end
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      check("rst post limit", issue_ready, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cfu_initiator.md
CFU_INITIATOR -- requirements
Module: cfu_initiator

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, SHALL set the maximum number of requests issued to the CFU without a response yet accepted (range 1..16).
REQ-002 Parameter ID_W, default 4, SHALL set the width of issue_id, cfu.req_id, cfu.resp_id and wb_id.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port issue_valid, input, 1: the core presents a CFU instruction.
REQ-006 Port issue_ready, output, 1: the block accepts the instruction this cycle.
REQ-007 Port issue_id, input, ID_W: instruction tag.
REQ-008 Port issue_fn, input, 10: function id.
REQ-009 Port issue_rs1 and issue_rs2, input, 32 each: operands.
REQ-010 Port wb_valid, output, 1; wb_ready, input, 1: writeback handshake to the core.
REQ-011 Port wb_id, output, ID_W; wb_data, output, 32; wb_error, output, 1: writeback payload.
REQ-012 Port id_mismatch, output, 1: sticky protocol-error flag.
REQ-013 Port cfu, cfu_interface.master: drives req_valid, req_id, req_function_id, req_data0, req_data1 and resp_ready; samples req_ready, resp_valid, resp_id, resp_status and resp_data.

Function
REQ-014 Issue handshake SHALL be issue_valid && issue_ready; request handshake SHALL be cfu.req_valid && cfu.req_ready; response handshake SHALL be cfu.resp_valid && cfu.resp_ready; writeback handshake SHALL be wb_valid && wb_ready.
REQ-015 A request register SHALL capture id, fn, rs1 and rs2 on issue handshake and SHALL drive cfu.req_* from registers; cfu.req_valid SHALL rise the cycle after issue, giving 1 cycle of latency.
REQ-016 While cfu.req_valid=1 and cfu.req_ready=0, all cfu.req_* outputs SHALL hold stable.
REQ-017 outstanding counter (0..MAX_OUTSTANDING) SHALL increment on request handshake and decrement on response handshake.
REQ-018 outstanding counter SHALL stay unchanged when both handshakes occur in the same cycle.
REQ-019 issue_ready SHALL equal (!cfu.req_valid || cfu.req_ready) && (outstanding + cfu.req_valid < MAX_OUTSTANDING), computed from registered state plus cfu.req_ready only.
REQ-020 Back-to-back issue SHALL sustain one request per cycle when the CFU holds req_ready=1, until the limit is reached.
REQ-021 A one-entry response buffer SHALL capture resp_id, resp_data and (resp_status != 0) on response handshake; wb_id, wb_data and wb_error SHALL be driven from that buffer.
REQ-022 cfu.resp_ready SHALL equal !wb_valid || wb_ready, so a response is accepted in the same cycle the buffered one drains.
REQ-023 wb_valid SHALL assert the cycle after response handshake and hold, with a stable payload, until writeback handshake.
REQ-024 The block SHALL never drop or duplicate a response, and SHALL NOT reorder responses relative to CFU response order.

Reset
REQ-025 On rst: cfu.req_valid=0, wb_valid=0, outstanding=0, id_mismatch=0, and the ID FIFO (when present) SHALL be empty; issue_ready and cfu.resp_ready SHALL read 1 in the first cycle after rst deasserts.
REQ-026 rst mid-operation SHALL discard held requests, buffered responses and in-flight tracking; payload registers need not reset.

Configuration
REQ-027 Macro CFU_ID_CHECK_EN, when defined, SHALL add an ID FIFO of depth MAX_OUTSTANDING that is pushed with req_id on request handshake and popped on response handshake.
REQ-028 With CFU_ID_CHECK_EN defined, a response handshake with resp_id != FIFO head SHALL set id_mismatch (sticky until rst) and force wb_error=1 for that response.
REQ-029 Without CFU_ID_CHECK_EN, no FIFO SHALL exist, id_mismatch SHALL be tied 0, and wb_id SHALL pass resp_id through the buffer unchecked.

Verification
REQ-030 Single op: issue id=3, fn=0x001, rs1=0x12345678; CFU returns id=3, status=0, data=0xCAFEF00D -> exactly one wb with id=3, data=0xCAFEF00D, wb_error=0.
REQ-031 Backpressure: CFU holds req_ready=0 for 5 cycles -> cfu.req_* stay stable, issue_ready=0, and a single request handshake occurs.
REQ-032 Limit: MAX_OUTSTANDING=4 with no responses -> 4 request handshakes, then issue_ready=0; one response plus writeback -> issue_ready returns to 1.
REQ-033 Writeback stall: wb_ready=0 with 2 responses pending -> cfu.resp_ready=0 after the first is buffered; releasing wb_ready gives ids in order with no loss.
REQ-034 Error: resp_status=2'b01 -> wb_error=1; with CFU_ID_CHECK_EN, issue ids 1 then 2 and CFU answers 2 first -> id_mismatch=1 and wb_error=1.
REQ-035 Reset: assert rst with 3 outstanding and wb_valid=1 -> the next cycle shows wb_valid=0, cfu.req_valid=0, issue_ready=1 and id_mismatch=0.
